sprite_line_scanner: RTL and testbench

Parametrised per-scanline object engine that generalises the fixed ten-bullet renderer to NUM_OBJ software-written objects, with at most MAX_PER_LINE drawn per line. It sits between the gamefile decode (object valid/x/y vectors) and the color mapper. It shadows the object table at frame boundaries so software updates never tear. While the current line is displayed, it scans the table for the next line into a double-buffered active list, then hit-tests DrawX/DrawY against that list.

---
 rtl/sprite_line_scanner.sv | 220 ++++++++++++++++++++++
 tb/tb_sprite_line_scanner.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_scanner.sv
// Per-scanline object engine: shadowed object table, one-object-per-cycle list
// builder for the next line, and a double-buffered display list hit test.

module sprite_line_scanner_hit #(
    parameter int COORD_W = 10,
    parameter int OBJ_W   = 4
) (
    input  logic               i_en,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_draw_x,
    output logic               o_hit
);
    localparam logic [COORD_W:0] W_C = (COORD_W+1)'(OBJ_W);

    logic [COORD_W:0] w_dx;

    // Extra bit keeps DrawX left of the object from aliasing into range.
    assign w_dx  = {1'b0, i_draw_x} - {1'b0, i_x};
    assign o_hit = i_en && (w_dx < W_C);
endmodule

module sprite_line_scanner #(
    parameter int NUM_OBJ      = 16,
    parameter int MAX_PER_LINE = 4,
    parameter int OBJ_W        = 4,
    parameter int OBJ_H        = 4,
    parameter int COORD_W      = 10
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         frame_start,
    input  logic [NUM_OBJ-1:0]           obj_valid,
    input  logic [NUM_OBJ*COORD_W-1:0]   obj_x,
    input  logic [NUM_OBJ*COORD_W-1:0]   obj_y,
    input  logic                         line_start,
    input  logic [COORD_W-1:0]           next_y,
    input  logic [COORD_W-1:0]           DrawX,
    input  logic [COORD_W-1:0]           DrawY,
    output logic                         is_obj,
    output logic [$clog2(NUM_OBJ)-1:0]   obj_idx,
    output logic                         line_ready,
    output logic                         overflow,
    output logic                         late
);
    localparam int IDX_W = $clog2(NUM_OBJ);
    localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_PER_LINE);
    localparam logic [COORD_W:0] H_C      = (COORD_W+1)'(OBJ_H);

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t r_state, w_state_nxt;

    logic [NUM_OBJ-1:0]  r_sh_valid;
    logic [COORD_W-1:0]  r_sh_x [NUM_OBJ];
    logic [COORD_W-1:0]  r_sh_y [NUM_OBJ];
    logic                r_pending;

    logic [IDX_W-1:0]    r_idx;
    logic [COORD_W-1:0]  r_target_y;
    logic [CNT_W-1:0]    r_bld_cnt;
    logic [IDX_W-1:0]    r_bld_idx [MAX_PER_LINE];
    logic [COORD_W-1:0]  r_bld_x   [MAX_PER_LINE];

    logic [CNT_W-1:0]    r_dsp_cnt;
    logic [IDX_W-1:0]    r_dsp_idx [MAX_PER_LINE];
    logic [COORD_W-1:0]  r_dsp_x   [MAX_PER_LINE];
    logic [COORD_W-1:0]  r_tag_y;

    logic                w_swap, w_restart, w_done, w_load_sh;
    logic [COORD_W:0]    w_dy;
    logic                w_obj_hit;
    logic                w_row_hit;
    logic [MAX_PER_LINE-1:0] w_ent_hit;
    logic [IDX_W-1:0]    w_hit_idx;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        w_restart   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (line_start) begin
                    w_swap      = 1'b1;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (line_start) begin
                    w_restart = 1'b1;
                end else if (r_idx == LAST_IDX) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A frame_start seen mid-scan is held until the scan ends so a line never mixes tables.
    assign w_load_sh = (r_state == S_IDLE && frame_start) || (w_done && (r_pending || frame_start));

    assign w_dy      = {1'b0, r_target_y} - {1'b0, r_sh_y[r_idx]};
    assign w_obj_hit = r_sh_valid[r_idx] && (w_dy < H_C);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sh_valid <= '0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_sh_x[i] <= '0;
                r_sh_y[i] <= '0;
            end
            r_pending  <= 1'b0;
            r_idx      <= '0;
            r_target_y <= '0;
            r_bld_cnt  <= '0;
            r_dsp_cnt  <= '0;
            r_tag_y    <= '0;
            for (int e = 0; e < MAX_PER_LINE; e++) begin
                r_bld_idx[e] <= '0;
                r_bld_x[e]   <= '0;
                r_dsp_idx[e] <= '0;
                r_dsp_x[e]   <= '0;
            end
            line_ready <= 1'b0;
            overflow   <= 1'b0;
            late       <= 1'b0;
        end else begin
            line_ready <= w_done;

            if (w_load_sh) begin
                for (int i = 0; i < NUM_OBJ; i++) begin
                    r_sh_valid[i] <= obj_valid[i];
                    r_sh_x[i]     <= obj_x[i*COORD_W +: COORD_W];
                    r_sh_y[i]     <= obj_y[i*COORD_W +: COORD_W];
                end
                r_pending <= 1'b0;
            end else if (frame_start) begin
                r_pending <= 1'b1;
            end

            if (frame_start) begin
                overflow <= 1'b0;
                late     <= 1'b0;
            end
            if (w_restart) late <= 1'b1;

            if (w_swap) begin
                r_dsp_cnt <= r_bld_cnt;
                r_tag_y   <= r_target_y;
                for (int e = 0; e < MAX_PER_LINE; e++) begin
                    r_dsp_idx[e] <= r_bld_idx[e];
                    r_dsp_x[e]   <= r_bld_x[e];
                end
            end else if (w_restart) begin
                r_dsp_cnt <= '0;
            end

            if (line_start) begin
                r_target_y <= next_y;
                r_bld_cnt  <= '0;
                r_idx      <= '0;
            end else if (r_state == S_SCAN) begin
                if (r_idx != LAST_IDX) r_idx <= r_idx + IDX_W'(1);
                if (w_obj_hit) begin
                    if (r_bld_cnt == MAX_C) begin
                        overflow <= 1'b1;
                    end else begin
                        for (int e = 0; e < MAX_PER_LINE; e++) begin
                            if (CNT_W'(e) == r_bld_cnt) begin
                                r_bld_idx[e] <= r_idx;
                                r_bld_x[e]   <= r_sh_x[r_idx];
                            end
                        end
                        r_bld_cnt <= r_bld_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign w_row_hit = (DrawY == r_tag_y);

    for (genvar e = 0; e < MAX_PER_LINE; e++) begin : g_ent
        sprite_line_scanner_hit #(
            .COORD_W (COORD_W),
            .OBJ_W   (OBJ_W)
        ) u_hit (
            .i_en     (w_row_hit && (CNT_W'(e) < r_dsp_cnt)),
            .i_x      (r_dsp_x[e]),
            .i_draw_x (DrawX),
            .o_hit    (w_ent_hit[e])
        );
    end

    // Entries are appended in index order, so the lowest hitting entry is the lowest object.
    always_comb begin
        w_hit_idx = '0;
        for (int e = MAX_PER_LINE - 1; e >= 0; e--) begin
            if (w_ent_hit[e]) w_hit_idx = r_dsp_idx[e];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            is_obj  <= 1'b0;
            obj_idx <= '0;
        end else begin
            is_obj  <= |w_ent_hit;
            obj_idx <= w_hit_idx;
        end
    end
endmodule

// File: tb/tb_sprite_line_scanner.sv
// Scoreboard bench for sprite_line_scanner: stimulus pushes expected line_ready
// cycles and hit results; a negedge monitor pops and compares.
module tb_sprite_line_scanner;
    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         frame_start = 1'b0;
    logic [15:0]  obj_valid = '0;
    logic [159:0] obj_x = '0;
    logic [159:0] obj_y = '0;
    logic         line_start = 1'b0;
    logic [9:0]   next_y = '0;
    logic [9:0]   DrawX = '0;
    logic [9:0]   DrawY = '0;
    logic         is_obj;
    logic [3:0]   obj_idx;
    logic         line_ready;
    logic         overflow;
    logic         late;

    sprite_line_scanner #(
        .NUM_OBJ(16), .MAX_PER_LINE(4), .OBJ_W(4), .OBJ_H(4), .COORD_W(10)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .obj_valid(obj_valid), .obj_x(obj_x), .obj_y(obj_y),
        .line_start(line_start), .next_y(next_y),
        .DrawX(DrawX), .DrawY(DrawY),
        .is_obj(is_obj), .obj_idx(obj_idx), .line_ready(line_ready),
        .overflow(overflow), .late(late)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } hit_exp_t;

    int       checks = 0;
    int       failures = 0;
    int       cyc = 0;
    int       rdy_q[$];
    hit_exp_t hit_q[$];
    logic     probe = 1'b0;
    logic     probe_d = 1'b0;

    always @(posedge Clk) begin
        cyc     <= cyc + 1;
        probe_d <= probe;
    end

    always @(negedge Clk) begin
        if (!Reset) begin
            if (line_ready) begin
                checks++;
                if (rdy_q.size() == 0) begin
                    failures++;
                    $display("FAIL line_ready: unexpected pulse at cycle %0d", cyc);
                end else begin
                    int e;
                    e = rdy_q.pop_front();
                    if (e != cyc) begin
                        failures++;
                        $display("FAIL line_ready: pulse at cycle %0d, expected cycle %0d", cyc, e);
                    end
                end
            end
            if (probe_d) begin
                hit_exp_t h;
                checks++;
                if (hit_q.size() == 0) begin
                    failures++;
                    $display("FAIL hit_q: probe with empty expectation queue");
                end else begin
                    h = hit_q.pop_front();
                    if (is_obj !== h.hit || (h.hit && obj_idx !== h.idx)) begin
                        failures++;
                        $display("FAIL hit X=%0d Y=%0d: is_obj=%0b obj_idx=%0d, expected is_obj=%0b obj_idx=%0d",
                                 DrawX, DrawY, is_obj, obj_idx, h.hit, h.idx);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_obj(input int i, input int x, input int y, input logic v);
        obj_valid[i]        = v;
        obj_x[i*10 +: 10]   = 10'(x);
        obj_y[i*10 +: 10]   = 10'(y);
    endtask

    task automatic clear_objs();
        obj_valid = '0;
        obj_x     = '0;
        obj_y     = '0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // exp_rdy=0 for scans that will be interrupted before they finish.
    task automatic pulse_line(input int y, input logic exp_rdy);
        line_start = 1'b1;
        next_y     = 10'(y);
        if (exp_rdy) rdy_q.push_back(cyc + 17);
        tick();
        line_start = 1'b0;
    endtask

    task automatic probe_hit(input int x, input int y, input logic h, input int idx);
        hit_exp_t e;
        DrawX = 10'(x);
        DrawY = 10'(y);
        e.hit = h;
        e.idx = 4'(idx);
        hit_q.push_back(e);
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    initial begin
        ticks(2);
        check("reset_is_obj", {31'd0, is_obj}, 0);
        check("reset_line_ready", {31'd0, line_ready}, 0);
        check("reset_overflow", {31'd0, overflow}, 0);
        check("reset_late", {31'd0, late}, 0);
        Reset = 1'b0;
        tick();

        // Single object 3 at (100,50)
        clear_objs();
        set_obj(3, 100, 50, 1'b1);
        pulse_frame();
        pulse_line(52, 1'b1);
        ticks(20);
        pulse_line(53, 1'b1);
        probe_hit(103, 52, 1'b1, 3);
        probe_hit(104, 52, 1'b0, 0);
        probe_hit(100, 52, 1'b1, 3);
        probe_hit(99, 52, 1'b0, 0);
        probe_hit(103, 51, 1'b0, 0);
        ticks(18);
        check("no_overflow_single", {31'd0, overflow}, 0);

        // Six objects on one line: only indices 0..3 kept
        clear_objs();
        set_obj(0, 0, 10, 1'b1);
        set_obj(1, 2, 10, 1'b1);
        set_obj(2, 40, 10, 1'b1);
        set_obj(3, 60, 10, 1'b1);
        set_obj(4, 80, 10, 1'b1);
        set_obj(5, 100, 10, 1'b1);
        pulse_frame();
        pulse_line(10, 1'b1);
        ticks(20);
        check("overflow_set", {31'd0, overflow}, 1);
        pulse_line(11, 1'b1);
        probe_hit(3, 10, 1'b1, 0);
        probe_hit(4, 10, 1'b1, 1);
        probe_hit(41, 10, 1'b1, 2);
        probe_hit(63, 10, 1'b1, 3);
        probe_hit(80, 10, 1'b0, 0);
        probe_hit(100, 10, 1'b0, 0);
        ticks(18);

        // Vertical boundaries: no wrap at the screen bottom
        clear_objs();
        set_obj(0, 200, 1020, 1'b1);
        set_obj(1, 300, 0, 1'b1);
        pulse_frame();
        check("overflow_cleared", {31'd0, overflow}, 0);
        pulse_line(2, 1'b1);
        ticks(20);
        pulse_line(3, 1'b1);
        probe_hit(200, 2, 1'b0, 0);
        probe_hit(300, 2, 1'b1, 1);
        probe_hit(303, 2, 1'b1, 1);
        ticks(18);
        pulse_line(4, 1'b1);
        probe_hit(300, 3, 1'b1, 1);
        ticks(19);
        pulse_line(1023, 1'b1);
        probe_hit(300, 4, 1'b0, 0);
        ticks(19);
        pulse_line(0, 1'b1);
        probe_hit(200, 1023, 1'b1, 0);
        probe_hit(203, 1023, 1'b1, 0);
        ticks(18);

        // Deferred shadow load: frame_start mid-scan
        clear_objs();
        set_obj(0, 50, 20, 1'b1);
        pulse_frame();
        pulse_line(20, 1'b1);
        ticks(20);
        set_obj(0, 50, 30, 1'b1);
        pulse_line(21, 1'b1);
        ticks(7);
        pulse_frame();
        ticks(12);
        pulse_line(30, 1'b1);
        probe_hit(50, 21, 1'b1, 0);
        ticks(19);
        pulse_line(31, 1'b1);
        probe_hit(50, 30, 1'b1, 0);
        probe_hit(50, 21, 1'b0, 0);
        ticks(18);

        // Late line_start: display emptied, scan restarts
        set_obj(0, 50, 40, 1'b1);
        pulse_frame();
        pulse_line(40, 1'b0);
        ticks(5);
        pulse_line(41, 1'b1);
        check("late_set", {31'd0, late}, 1);
        probe_hit(50, 31, 1'b0, 0);
        ticks(19);
        pulse_line(42, 1'b0);
        probe_hit(50, 41, 1'b1, 0);
        check("late_sticky", {31'd0, late}, 1);
        pulse_frame();
        check("late_cleared", {31'd0, late}, 0);
        tick();
        check("pre_reset_is_obj", {31'd0, is_obj}, 1);

        // Asynchronous reset mid-scan
        Reset = 1'b1;
        #1;
        check("rst_is_obj", {31'd0, is_obj}, 0);
        check("rst_obj_idx", {28'd0, obj_idx}, 0);
        check("rst_line_ready", {31'd0, line_ready}, 0);
        check("rst_late", {31'd0, late}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        tick();
        Reset = 1'b0;
        ticks(3);
        check("post_rst_list_empty", {31'd0, is_obj}, 0);
        ticks(20);
        pulse_frame();
        pulse_line(41, 1'b1);
        ticks(20);
        pulse_line(0, 1'b1);
        probe_hit(50, 41, 1'b1, 0);
        ticks(19);

        check("rdy_q_drained", rdy_q.size(), 0);
        check("hit_q_drained", hit_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
